idx_collector: RTL and testbench
================================

IDX_COLLECTOR -- requirements
Module: idx_collector

Interface
REQ-001 The block SHALL have parameter CHUNK_W, default 8: flag bits per accepted chunk.
REQ-002 The block SHALL have parameter NUM_CHUNKS, default 8: chunks per frame, giving 64 positions.
REQ-003 The block SHALL have parameter IDX_W, default 6: index width, equal to clog2(CHUNK_W*NUM_CHUNKS).
REQ-004 The block SHALL have the following ports, one per line as name / direction / width / meaning:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle frame start pulse.
- i_valid  in  1  i_flags is valid this cycle.
- i_flags  in  CHUNK_W  flag chunk; bit b set means position chunk_cnt*CHUNK_W+b is selected.
- o_ready  out  1  chunk is accepted when i_valid and o_ready are both high.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse; result outputs are valid.
- o_idx1..o_idx4  out  IDX_W each  first four selected positions, ascending.
- o_num  out  3  count of selected positions, saturated at 4.
- o_overflow  out  1  more than 4 positions were set in the frame.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, COLLECT and DONE.
REQ-006 Transition IDLE->COLLECT SHALL occur on i_start; this clears the accumulator (idx slots 0, num 0, overflow 0) and sets chunk_cnt to 0.
REQ-007 o_ready SHALL be 1 only in COLLECT; o_busy SHALL be 1 in COLLECT and DONE.
REQ-008 On each accepted chunk, the chunk's set bits SHALL be compacted lowest bit first into up to 4 indices {chunk_cnt, b}, with a chunk count c of 0..CHUNK_W.
REQ-009 Merge rule: the chunk's indices SHALL be appended after the existing n entries, filling slot n+1 onward; slots beyond 4 are dropped and held slots never change.
REQ-010 o_num SHALL update to min(n+c, 4) each accepted chunk.
REQ-011 o_overflow SHALL be set sticky when n+c>4; a chunk with more than 4 set bits also sets it, and width is kept adequate so no wrap occurs.
REQ-012 chunk_cnt SHALL increment per accepted chunk; accepting chunk NUM_CHUNKS-1 SHALL transition COLLECT->DONE.
REQ-013 A cycle with i_valid=0 in COLLECT SHALL leave all state unchanged (stall).
REQ-014 In DONE, o_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-015 Latency: o_done SHALL assert in the cycle after the edge that accepts the last chunk.
REQ-016 o_idx*, o_num and o_overflow SHALL hold the frame result until the next i_start is taken.
REQ-017 Unfilled slots (slot index > o_num) SHALL read 0.
REQ-018 i_start SHALL be ignored in COLLECT and DONE (no restart mid-frame).
REQ-019 i_valid outside COLLECT SHALL be ignored.

Reset
REQ-020 Asserting i_rst_n low SHALL asynchronously force state IDLE, chunk_cnt 0, o_idx1..4 0, o_num 0, o_overflow 0, o_done 0, o_ready 0 and o_busy 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no o_done; the first i_start after deassertion SHALL begin a clean frame.

Structure
REQ-022 Package idx_pkg SHALL hold CHUNK_W, NUM_CHUNKS, IDX_W, MAX_IDX=4 and the state encoding.
REQ-023 Chunk compaction SHALL be a combinational sub-module idx_chunk_compact producing four local indices and a count; the append/merge and FSM SHALL be in idx_collector.
REQ-024 The accumulator and FSM SHALL be the only sequential elements; the merge path SHALL be single-cycle.

Verification
REQ-025 Single flag: start; chunk0=8'h00, chunk1=8'h04, chunks2-7=0 -> o_done one cycle after 8th accept; o_idx1=10, o_num=1, others 0, overflow 0.
REQ-026 Exact fill across chunks: chunk0=8'h81, chunk3=8'h03, rest 0 -> idx={0,7,24,25}, num=4, overflow 0.
REQ-027 Overflow: chunk0=8'hFF -> idx={0,1,2,3}, num=4, overflow 1; later chunks with set bits do not alter the idx slots.
REQ-028 Stalls and ignored start: random i_valid gaps plus an i_start pulse mid-frame -> results match the no-stall run and o_done occurs only after 8 accepts.
REQ-029 Reset mid-frame: deassert i_rst_n after 3 chunks -> all outputs 0 immediately; a new frame with chunk7=8'h80 -> idx1=63, num=1.
REQ-030 Back-to-back frames: i_start in the cycle after o_done -> accumulator cleared, and the second frame's results are independent of the first.

Source files
------------

// File: rtl/idx_pkg.sv
// rtl/idx_pkg.sv - shared sizing constants and FSM encoding for the index collector
package idx_pkg;
    localparam int CHUNK_W    = 8;
    localparam int NUM_CHUNKS = 8;
    localparam int IDX_W      = 6;
    localparam int MAX_IDX    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;
endpackage

// File: rtl/idx_chunk_compact.sv
// rtl/idx_chunk_compact.sv - compacts set flag bits of one chunk into up to four local indices
module idx_chunk_compact
    import idx_pkg::*;
#(
    parameter int CW    = 8,
    parameter int LB_W  = 3,
    parameter int CNT_W = 4
) (
    input  logic [CW-1:0]        i_flags,
    output logic [4*LB_W-1:0]    o_loc,
    output logic [CNT_W-1:0]     o_cnt
);

    int cnt;

    // Lowest set bit lands in slot 0; bits past the fourth still count toward o_cnt.
    always_comb begin
        o_loc = '0;
        cnt   = 0;
        for (int b = 0; b < CW; b++) begin
            if (i_flags[b]) begin
                if (cnt < MAX_IDX) begin
                    o_loc[cnt*LB_W +: LB_W] = LB_W'(b);
                end
                cnt = cnt + 1;
            end
        end
        o_cnt = CNT_W'(cnt);
    end

endmodule

// File: rtl/idx_collector.sv
// rtl/idx_collector.sv - collects the first four selected positions of a chunked flag frame
module idx_collector #(
    parameter int CHUNK_W    = idx_pkg::CHUNK_W,
    parameter int NUM_CHUNKS = idx_pkg::NUM_CHUNKS,
    parameter int IDX_W      = idx_pkg::IDX_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_valid,
    input  logic [CHUNK_W-1:0] i_flags,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [IDX_W-1:0]   o_idx1,
    output logic [IDX_W-1:0]   o_idx2,
    output logic [IDX_W-1:0]   o_idx3,
    output logic [IDX_W-1:0]   o_idx4,
    output logic [2:0]         o_num,
    output logic               o_overflow
);
    import idx_pkg::*;

    localparam int LB_W  = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
    localparam int CNT_W = $clog2(CHUNK_W + 1);
    localparam int CC_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    state_e            state_q, state_d;
    logic [CC_W-1:0]   chunk_cnt_q, chunk_cnt_d;
    logic [IDX_W-1:0]  idx_q [MAX_IDX];
    logic [IDX_W-1:0]  idx_d [MAX_IDX];
    logic [2:0]        num_q, num_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [4*LB_W-1:0] loc;
    logic [CNT_W-1:0]  loc_cnt;
    logic [IDX_W-1:0]  base;
    int                n;
    int                c;
    int                sum;

    idx_chunk_compact #(
        .CW    (CHUNK_W),
        .LB_W  (LB_W),
        .CNT_W (CNT_W)
    ) u_compact (
        .i_flags (i_flags),
        .o_loc   (loc),
        .o_cnt   (loc_cnt)
    );

    always_comb begin
        state_d     = state_q;
        chunk_cnt_d = chunk_cnt_q;
        for (int s = 0; s < MAX_IDX; s++) begin
            idx_d[s] = idx_q[s];
        end
        num_d = num_q;
        ovf_d = ovf_q;
        n     = int'(num_q);
        c     = int'(loc_cnt);
        sum   = n + c;
        base  = IDX_W'(chunk_cnt_q) * IDX_W'(CHUNK_W);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_COLLECT;
                    chunk_cnt_d = '0;
                    for (int s = 0; s < MAX_IDX; s++) begin
                        idx_d[s] = '0;
                    end
                    num_d = '0;
                    ovf_d = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (i_valid) begin
                    // New indices append after the n held slots; held slots are never rewritten.
                    for (int s = 0; s < MAX_IDX; s++) begin
                        if (s >= n && (s - n) < c) begin
                            idx_d[s] = base + IDX_W'(loc[(s-n)*LB_W +: LB_W]);
                        end
                    end
                    num_d       = (sum > MAX_IDX) ? 3'(MAX_IDX) : 3'(sum);
                    ovf_d       = ovf_q | (sum > MAX_IDX);
                    chunk_cnt_d = chunk_cnt_q + 1'b1;
                    if (chunk_cnt_q == CC_W'(NUM_CHUNKS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_COLLECT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            chunk_cnt_q <= '0;
            for (int s = 0; s < MAX_IDX; s++) begin
                idx_q[s] <= '0;
            end
            num_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            for (int s = 0; s < MAX_IDX; s++) begin
                idx_q[s] <= idx_d[s];
            end
            num_q   <= num_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_idx1     = idx_q[0];
    assign o_idx2     = idx_q[1];
    assign o_idx3     = idx_q[2];
    assign o_idx4     = idx_q[3];
    assign o_num      = num_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_idx_collector.sv
// tb/tb_idx_collector.sv - table-driven bench for the index collector
module tb_idx_collector;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       valid;
    logic [7:0] flags;
    logic       ready;
    logic       busy;
    logic       done;
    logic [5:0] idx1, idx2, idx3, idx4;
    logic [2:0] num;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    idx_collector dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_valid    (valid),
        .i_flags    (flags),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_idx1     (idx1),
        .o_idx2     (idx2),
        .o_idx3     (idx3),
        .o_idx4     (idx4),
        .o_num      (num),
        .o_overflow (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] fl;
        logic [5:0]  e1, e2, e3, e4;
        logic [2:0]  en;
        logic        eov;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, " idx1"}, 32'(idx1), 32'(v.e1));
        check({tag, " idx2"}, 32'(idx2), 32'(v.e2));
        check({tag, " idx3"}, 32'(idx3), 32'(v.e3));
        check({tag, " idx4"}, 32'(idx4), 32'(v.e4));
        check({tag, " num"},  32'(num),  32'(v.en));
        check({tag, " ovf"},  32'(ovf),  32'(v.eov));
    endtask

    // Starts immediately (caller is #1 after an edge), feeds 8 chunks, checks done timing.
    task automatic run_frame(input string tag, input logic [63:0] fl, input bit stall, input bit mid_start);
        int  k;
        int  guard;
        bit  acc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " ready after start"}, 32'(ready), 32'd1);
        check({tag, " num cleared"}, 32'(num), 32'd0);
        check({tag, " idx1 cleared"}, 32'(idx1), 32'd0);
        check({tag, " ovf cleared"}, 32'(ovf), 32'd0);
        k = 0;
        guard = 0;
        while (k < 8 && guard < 200) begin
            guard++;
            if (stall && $urandom_range(0, 2) == 0) begin
                valid = 1'b0;
                flags = 8'hFF;
            end else begin
                valid = 1'b1;
                flags = fl[k*8 +: 8];
            end
            start = (mid_start && k == 3) ? 1'b1 : 1'b0;
            acc = valid && ready;
            @(posedge clk); #1;
            valid = 1'b0;
            start = 1'b0;
            if (acc) k++;
            check({tag, " done timing"}, 32'(done), (k == 8) ? 32'd1 : 32'd0);
            if (k < 8) check({tag, " busy"}, 32'(busy), 32'd1);
        end
        if (k < 8) begin
            failures++;
            $display("FAIL %s: timeout, accepted %0d of 8 chunks", tag, k);
        end
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    vec_t v;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_0400, 6'd10, 6'd0,  6'd0,  6'd0,  3'd1, 1'b0};
        vecs[1] = '{64'h0000_0000_0300_0081, 6'd0,  6'd7,  6'd24, 6'd25, 3'd4, 1'b0};
        vecs[2] = '{64'h0000_1000_0000_00FF, 6'd0,  6'd1,  6'd2,  6'd3,  3'd4, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_0000, 6'd0,  6'd0,  6'd0,  6'd0,  3'd0, 1'b0};
        vecs[4] = '{64'hF000_0000_0000_0000, 6'd60, 6'd61, 6'd62, 6'd63, 3'd4, 1'b0};
        vecs[5] = '{64'h0080_2200_0001_0000, 6'd16, 6'd41, 6'd45, 6'd55, 3'd4, 1'b0};
        vecs[6] = '{64'h0000_0000_0001_0F00, 6'd8,  6'd9,  6'd10, 6'd11, 3'd4, 1'b1};
        vecs[7] = '{64'h0200_0000_0000_0040, 6'd6,  6'd57, 6'd0,  6'd0,  3'd2, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        flags = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        v = '{64'h0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0};
        check_result("reset", v);
        check("reset ready", 32'(ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frames run back to back: each start is driven in the cycle after done.
        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].fl, 1'b0, 1'b0);
            check_result($sformatf("vec%0d", i), vecs[i]);
        end

        // Results hold while idle and stray valid chunks are ignored.
        valid = 1'b1;
        flags = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        check_result("hold", vecs[7]);
        check("hold ready", 32'(ready), 32'd0);

        run_frame("stall", vecs[1].fl, 1'b1, 1'b1);
        check_result("stall", vecs[1]);
        run_frame("stall2", vecs[5].fl, 1'b1, 1'b1);
        check_result("stall2", vecs[5]);

        // Reset mid-frame after three chunks.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        valid = 1'b1;
        flags = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        check("pre-reset num", 32'(num), 32'd4);
        rst_n = 1'b0;
        #1;
        v = '{64'h0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0};
        check_result("async reset", v);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("no done after reset", 32'(done), 32'd0);
        end
        v = '{64'h8000_0000_0000_0000, 6'd63, 6'd0, 6'd0, 6'd0, 3'd1, 1'b0};
        run_frame("post-reset", v.fl, 1'b0, 1'b0);
        check_result("post-reset", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
